// File: rtl/rr_mux4_sched_pkg.sv
// rr_mux4_sched_pkg: shared FSM encoding, sizes and round-robin pick helper
package rr_mux4_sched_pkg;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;
    localparam int   NREQ     = 4;
    localparam int   SELW     = 2;

    function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] mask, input logic [SELW-1:0] start);
        logic [SELW-1:0] w, idx;
        w = start;
        // walk from the farthest slot back so the closest hit to start wins
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = start + SELW'(k);
            if (mask[idx]) w = idx;
        end
        return w;
    endfunction
endpackage

// File: rtl/rr_mux4_sched_if.sv
// rr_mux4_sched_if: requester-side bus of the shared mux scheduler
interface rr_mux4_sched_if
    import rr_mux4_sched_pkg::*;
#(parameter int W = 2);
    logic [NREQ-1:0] req;
    logic [W-1:0]    d0, d1, d2, d3;
    logic [NREQ-1:0] gnt;
    logic [SELW-1:0] sel;
    logic            valid;
    logic [W-1:0]    y;
    modport master(output req, d0, d1, d2, d3, input gnt, sel, valid, y);
    modport slave(input req, d0, d1, d2, d3, output gnt, sel, valid, y);
endinterface

// File: rtl/rr_mux4_sched_mux4_w.sv
// mux4_w: W-bit 4:1 combinational mux
module mux4_w #(parameter int W = 2) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);
    always_comb y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/rr_mux4_sched.sv
// rr_mux4_sched: round-robin scheduler sharing one 4:1 mux among four requesters
module rr_mux4_sched
    import rr_mux4_sched_pkg::*;
#(
    parameter int W        = 2,
    parameter int MAX_HOLD = 4
) (
    input logic             clk,
    input logic             rst,
    rr_mux4_sched_if.slave  bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic            state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [NREQ-1:0] others;
    logic [SELW-1:0] nxt;
    logic            rel;
    logic [W-1:0]    mux_y;

    assign others = bus.req & ~(NREQ'(1) << sel_q);
    assign nxt    = sel_q + SELW'(1);
    assign rel    = !bus.req[sel_q] || hold_q == HW'(MAX_HOLD);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        if (state_q == ST_IDLE) begin
            if (|bus.req) begin
                state_d = ST_GRANT;
                sel_d   = rr_pick(bus.req, ptr_q);
                hold_d  = HW'(1);
            end
        end else if (!rel) begin
            hold_d = hold_q + HW'(1);
        end else begin
            // release: others first, then the same holder, else go idle
            ptr_d   = nxt;
            sel_d   = |others ? rr_pick(others, nxt) : sel_q;
            state_d = (|others || bus.req[sel_q]) ? ST_GRANT : ST_IDLE;
            hold_d  = (state_d == ST_GRANT) ? HW'(1) : '0;
        end
        gnt_d = (state_d == ST_GRANT) ? NREQ'(1) << sel_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    mux4_w #(.W(W)) u_mux (
        .d0 (bus.d0),
        .d1 (bus.d1),
        .d2 (bus.d2),
        .d3 (bus.d3),
        .sel(sel_q),
        .y  (mux_y)
    );

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = state_q;
    assign bus.y     = state_q ? mux_y : '0;
endmodule

// File: tb/tb_rr_mux4_sched.sv
// tb_rr_mux4_sched: directed scoreboard bench plus random fairness/invariant run
module tb_rr_mux4_sched;
    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic [1:0] y;
    } exp_t;

    localparam logic [7:0] DA = 8'b11_10_01_00;
    localparam logic [7:0] DB = 8'b11_10_10_00;
    localparam logic [7:0] DX = 8'b10_00_11_01;
    localparam logic [7:0] DC = 8'b11_01_01_00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic armed = 1'b0;
    logic rnd = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   wait_cnt [4];
    exp_t expq [$];

    rr_mux4_sched_if #(.W(2)) bus();

    rr_mux4_sched #(.W(2), .MAX_HOLD(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [7:0] dd,
                        input logic [3:0] g, input logic [1:0] s, input logic v, input logic [1:0] yy);
        @(negedge clk);
        rst = r;
        bus.req = rq;
        {bus.d3, bus.d2, bus.d1, bus.d0} = dd;
        expq.push_back('{g, s, v, yy});
    endtask

    initial begin
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
        forever begin
            exp_t e;
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("gnt", 8'(bus.gnt), 8'(e.gnt));
                check("sel", 8'(bus.sel), 8'(e.sel));
                check("valid", 8'(bus.valid), 8'(e.valid));
                check("y", 8'(bus.y), 8'(e.y));
                armed = 1'b1;
            end
            if (armed) begin
                check("onehot0", 8'($onehot0(bus.gnt)), 8'd1);
                check("gnt_vs_sel", 8'(bus.gnt), bus.valid ? 8'(4'b1 << bus.sel) : 8'd0);
            end
            if (rnd) begin
                for (int i = 0; i < 4; i++) begin
                    wait_cnt[i] = (bus.req[i] && !bus.gnt[i]) ? wait_cnt[i] + 1 : 0;
                    check($sformatf("wait%0d_le12", i), 8'(wait_cnt[i] <= 12), 8'd1);
                end
            end
        end
    end

    initial begin
        bus.req = '0;
        {bus.d3, bus.d2, bus.d1, bus.d0} = DA;
        step(1, 4'b0000, DA, 4'b0000, 0, 0, 0);
        step(1, 4'b0000, DA, 4'b0000, 0, 0, 0);
        // grant, then reset mid-grant, then regrant after reset
        step(0, 4'b0100, DA, 4'b0100, 2, 1, 2);
        step(0, 4'b0100, DA, 4'b0100, 2, 1, 2);
        step(1, 4'b0100, DA, 4'b0000, 0, 0, 0);
        step(0, 4'b0100, DA, 4'b0100, 2, 1, 2);
        step(0, 4'b0000, DA, 4'b0000, 2, 0, 0);
        // lone requester 1 across a hold expiry, ptr=3 so search wraps to 1
        for (int i = 0; i < 7; i++) step(0, 4'b0010, DB, 4'b0010, 1, 1, 2);
        // everyone requesting: 1 finishes its hold, then 2,3,0 for 4 cycles each
        step(0, 4'b1111, DA, 4'b0010, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 4'b1111, DA, 4'b0100, 2, 1, 2);
        for (int i = 0; i < 4; i++) step(0, 4'b1111, DA, 4'b1000, 3, 1, 3);
        for (int i = 0; i < 4; i++) step(0, 4'b1111, DA, 4'b0001, 0, 1, 0);
        step(0, 4'b1111, DA, 4'b0010, 1, 1, 1);
        // early drop of 3 wraps straight to 0 with no bubble
        step(0, 4'b1000, DX, 4'b1000, 3, 1, 2);
        step(0, 4'b1001, DX, 4'b1000, 3, 1, 2);
        step(0, 4'b1001, DX, 4'b1000, 3, 1, 2);
        step(0, 4'b0001, DX, 4'b0001, 0, 1, 1);
        // idle transition, then ptr=1 favours requester 1
        step(0, 4'b0000, DX, 4'b0000, 0, 0, 0);
        step(0, 4'b0001, DX, 4'b0001, 0, 1, 1);
        step(0, 4'b0000, DX, 4'b0000, 0, 0, 0);
        step(0, 4'b0011, DX, 4'b0010, 1, 1, 3);
        step(0, 4'b0011, DX, 4'b0010, 1, 1, 3);
        step(0, 4'b0000, DX, 4'b0000, 1, 0, 0);
        // data change on the selected input reaches y in the same cycle
        step(0, 4'b0100, DA, 4'b0100, 2, 1, 2);
        step(0, 4'b0100, DC, 4'b0100, 2, 1, 1);
        step(0, 4'b0000, DC, 4'b0000, 2, 0, 0);
        @(negedge clk);
        rnd = 1'b1;
        for (int n = 0; n < 300; n++) begin
            bus.req = 4'($urandom_range(0, 15));
            {bus.d3, bus.d2, bus.d1, bus.d0} = 8'($urandom);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        rnd = 1'b0;
        bus.req = '0;
        repeat (3) @(negedge clk);
        check("queue_empty", 8'(expq.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_mux4_sched.md
Name: rr_mux4_sched

Overview:
- Round-robin scheduler that shares one 4-to-1, W-bit mux datapath between four requesters.
- Each requester raises req[i] and presents its data on d_i.
- The block grants the mux to one requester at a time, drives the select, and presents the selected data on y with a valid flag.
- Sits between the switch/key front end and the LED/output stage, and replaces a fixed, externally driven select.

Parameters:
- W, 2: data width per requester and of y.
- MAX_HOLD, 4: maximum consecutive cycles one requester may hold the grant; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i belongs to d_i.
- d0  input  W  requester 0 data.
- d1  input  W  requester 1 data.
- d2  input  W  requester 2 data.
- d3  input  W  requester 3 data.
- gnt  output  4  one-hot grant, registered; 0 when idle.
- sel  output  2  mux select, registered; index of the current grant holder.
- valid  output  1  registered; 1 while a grant is active.
- y  output  W  combinational; equals d[sel] when valid=1, otherwise all zeros.

Behaviour:
- Reset: clk and rst are fixed as above; rst is sampled only on the clk edge.
  - rst=1 at an edge sets state=IDLE, gnt=0, sel=0, valid=0, ptr=0 and hold_cnt=0; therefore y=0.
  - rst has priority over every other event, including mid-grant; the active grant is dropped with no completion.
- Internal state:
  - ptr (2 bits): the highest-priority index for the next search.
  - hold_cnt: width $clog2(MAX_HOLD+1).
  - FSM with two states, IDLE and GRANT.
- Search function: winner = first i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1 in the evaluated mask.
- IDLE:
  - If req != 0 at an edge: state becomes GRANT; sel=winner over the full req mask; gnt=1<<winner; valid=1; hold_cnt=1.
  - Latency: req rising in cycle n gives gnt/valid visible in cycle n+1.
- GRANT, release condition: req[sel]=0 OR hold_cnt==MAX_HOLD.
  - No release: gnt and sel are held; hold_cnt increments.
  - On release: ptr=sel+1 (mod 4, natural wrap from 3 to 0).
    - The search uses a mask of req with bit sel cleared, starting from sel+1.
    - If that masked mask is non-zero: regrant to the winner in the same edge (back-to-back, no idle bubble); hold_cnt=1.
    - Else, if req[sel] is still 1 (the hold expired and it is the only requester): regrant to the same requester; hold_cnt=1.
    - Else: go to IDLE with gnt=0 and valid=0; sel keeps its last value.
- Simultaneous events: request drop and hold expiry in the same cycle produce a single release. New requests arriving during a grant are only considered at release.
- Invariants:
  - gnt is always 0 or one-hot.
  - gnt == (valid ? 1<<sel : 0).
  - No requester waits more than 3*MAX_HOLD cycles while its req stays high.
- y is purely combinational from sel, valid and d*. A change on d[sel] reaches y in the same cycle.

Decomposition:
- Shared package holds:
  - localparams for the FSM encoding: ST_IDLE=1'b0, ST_GRANT=1'b1.
  - NREQ=4.
  - SELW=2.
  - a function rr_pick(mask[3:0], start[1:0]) returning the 2-bit winner, reused by future arbiters.
- Sub-module: mux4_w, a parameterised W-bit 4:1 combinational mux (d0..d3, sel, y). It is instantiated once; valid-gating of y is done in the parent.

Test Plan:
- Reset mid-grant:
  - Stimulus: req=4'b0100, wait 2 cycles, assert rst for 1 cycle.
  - Response: the cycle after rst shows gnt=0, valid=0, sel=0, y=0. With req still 4'b0100, gnt=4'b0100 reappears one cycle after rst deasserts.
- Single requester, hold expiry:
  - Stimulus: req=4'b0010 held, d1=2'b10, MAX_HOLD=4.
  - Response: gnt=4'b0010 from cycle 1 continuously, regranted to itself every 4 cycles with no gap; y=2'b10 throughout.
- All requesting:
  - Stimulus: req=4'b1111 held; d0=0, d1=1, d2=2, d3=3.
  - Response: sel sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…; y tracks sel; no idle cycle.
- Early drop with wrap:
  - Stimulus: grant held by 3 (ptr=3 initially via prior traffic); req=4'b1001; drop req[3] after 2 cycles.
  - Response: next edge grants 0 (gnt=4'b0001) with no bubble; ptr becomes 0.
- Idle transition:
  - Stimulus: req=4'b0001 for 1 cycle then 0.
  - Response: gnt=4'b0001 for exactly 1 cycle, then IDLE with valid=0 and y=0. A later req=4'b0011 grants 1 first, because ptr=1.
- Fairness:
  - Stimulus: random req with each bit held ≥1 cycle.
  - Response: assertions on the one-hot invariant, gnt/sel consistency, and maximum wait ≤12 cycles.
